// File: rtl/hash_feat_collect.sv
// Collects one interpolated feature word per hash-grid level into a single
// vector, then queues finished vectors in a 2-entry output FIFO.
module hash_feat_collect #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_LEVEL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 start_ready,
  output logic [NUM_LEVEL-1:0] level_en,
  input  logic [NUM_LEVEL-1:0] level_done,
  input  logic [DATA_SIZE-1:0] level_feat [0:NUM_LEVEL-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_feat [0:NUM_LEVEL-1],
  output logic                 busy,
  output logic                 err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] COLLECT = 2'd2;
  localparam logic [1:0] PUSH    = 2'd3;

  logic [1:0]           state;
  logic [NUM_LEVEL-1:0] mask;
  logic [DATA_SIZE-1:0] stage    [0:NUM_LEVEL-1];
  logic [DATA_SIZE-1:0] fifo_mem [0:1][0:NUM_LEVEL-1];
  logic [1:0]           count;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic                 push;
  logic                 pop;
  logic [1:0]           count_after_pop;
  logic                 rd_ptr_next;

  assign start_ready     = (state == IDLE) && (count < 2'd2);
  assign level_en        = (state == ISSUE) ? {NUM_LEVEL{1'b1}} : {NUM_LEVEL{1'b0}};
  assign busy            = (state != IDLE);
  assign push            = (state == PUSH);
  assign pop             = out_valid && out_ready;
  assign count_after_pop = count - {1'b0, pop};
  assign rd_ptr_next     = rd_ptr ^ pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|level_done) err <= 1'b1;
          if (start && start_ready) begin
            state <= ISSUE;
            mask  <= '0;
          end
        end
        ISSUE: begin
          if (|level_done) err <= 1'b1;
          state <= COLLECT;
        end
        COLLECT: begin
          // A repeated completion for an already-captured level is a protocol error.
          if (|(level_done & mask)) err <= 1'b1;
          mask <= mask | level_done;
          if (&(mask | level_done)) state <= PUSH;
        end
        PUSH: begin
          if (|level_done) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEVEL; i++) begin
      if (state == COLLECT && level_done[i] && !mask[i]) stage[i] <= level_feat[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_LEVEL; i++) fifo_mem[wr_ptr][i] <= stage[i];
    end
  end

  // Output register is loaded from entries already in the FIFO, so a vector
  // pushed at one edge becomes visible one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_LEVEL; i++) out_feat[i] <= '0;
    end else begin
      count     <= count + {1'b0, push} - {1'b0, pop};
      wr_ptr    <= wr_ptr ^ push;
      rd_ptr    <= rd_ptr_next;
      out_valid <= (count_after_pop != 2'd0);
      if (count_after_pop != 2'd0) begin
        for (int i = 0; i < NUM_LEVEL; i++) out_feat[i] <= fifo_mem[rd_ptr_next][i];
      end
    end
  end

endmodule

// File: tb/tb_hash_feat_collect.sv
// Randomized scoreboard bench for hash_feat_collect: stimulus pushes expected
// vectors, a negedge monitor pops and compares on every accepted output.
module tb_hash_feat_collect;

  localparam int DS = 32;
  localparam int NL = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          start_ready;
  logic [NL-1:0] level_en;
  logic [NL-1:0] level_done;
  logic [DS-1:0] level_feat [0:NL-1];
  logic          out_valid;
  logic          out_ready;
  logic [DS-1:0] out_feat [0:NL-1];
  logic          busy;
  logic          err;

  int compared;
  int mismatched;
  int ready_mode;
  logic [NL*DS-1:0] sb [$];
  logic [NL*DS-1:0] mon_exp;

  hash_feat_collect #(.DATA_SIZE(DS), .NUM_LEVEL(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .level_en(level_en), .level_done(level_done), .level_feat(level_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_feat(out_feat),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer: 0 = always ready, 1 = stalled, otherwise random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        for (int i = 0; i < NL; i++)
          checkOutput($sformatf("out_feat[%0d]", i), 64'(out_feat[i]), 64'(mon_exp[i*DS +: DS]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic launch();
    int guard;
    guard = 0;
    while (!start_ready && guard < 300) begin
      tick();
      guard++;
    end
    checkOutput("start_ready_wait", 64'(start_ready), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("level_en_issue", 64'(level_en), 64'({NL{1'b1}}));
    tick();
    checkOutput("level_en_collect", 64'(level_en), 64'd0);
  endtask

  // mode 0: random grouping, 1: all at once with feat=i+1,
  // 2: one level per cycle in order, 3: like 2 with a second done on level 5.
  task automatic applyStimulus(input int mode);
    logic [NL-1:0]    pending;
    logic [NL*DS-1:0] exp;
    logic [31:0]      r;
    bit               dup_sent;
    launch();
    pending  = '1;
    exp      = '0;
    dup_sent = 1'b0;
    while (pending != '0) begin
      for (int i = 0; i < NL; i++) level_feat[i] = $urandom;
      r = $urandom;
      case (mode)
        0: level_done = pending & r[NL-1:0];
        1: begin
          level_done = pending;
          for (int i = 0; i < NL; i++) level_feat[i] = DS'(i + 1);
        end
        default: level_done = pending & (~pending + 1'b1);
      endcase
      if (mode == 3 && level_done[5]) level_feat[5] = 32'hA;
      if (mode == 3 && !pending[5] && !dup_sent) begin
        level_done[5] = 1'b1;
        level_feat[5] = 32'hB;
        dup_sent      = 1'b1;
      end
      for (int i = 0; i < NL; i++)
        if (level_done[i] && pending[i]) exp[i*DS +: DS] = level_feat[i];
      pending = pending & ~level_done;
      tick();
    end
    level_done = '0;
    sb.push_back(exp);
  endtask

  task automatic drain();
    int guard;
    ready_mode = 0;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [DS-1:0] held;

  initial begin
    compared   = 0;
    mismatched = 0;
    ready_mode = 0;
    out_ready  = 1'b1;
    rst        = 1'b1;
    start      = 1'b0;
    level_done = '0;
    for (int i = 0; i < NL; i++) level_feat[i] = '0;

    doReset();
    checkOutput("reset_start_ready", 64'(start_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_level_en", 64'(level_en), 64'd0);
    checkOutput("reset_out_feat0", 64'(out_feat[0]), 64'd0);

    // Basic flow and latency from the last completion edge.
    applyStimulus(1);
    checkOutput("lat_push_cycle", 64'(out_valid), 64'd0);
    tick();
    checkOutput("lat_t1", 64'(out_valid), 64'd0);
    tick();
    checkOutput("lat_t2", 64'(out_valid), 64'd1);
    drain();
    checkOutput("basic_err", 64'(err), 64'd0);

    applyStimulus(2);
    drain();

    ready_mode = 2;
    for (int n = 0; n < 20; n++) applyStimulus(0);
    drain();
    checkOutput("random_err", 64'(err), 64'd0);

    // Backpressure: two queued vectors block a third start.
    ready_mode = 1;
    tick();
    applyStimulus(0);
    applyStimulus(0);
    repeat (3) tick();
    checkOutput("bp_start_ready", 64'(start_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    held  = out_feat[0];
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    checkOutput("bp_not_accepted", 64'(busy), 64'd0);
    checkOutput("bp_hold", 64'(out_feat[0]), 64'(held));
    ready_mode = 0;
    applyStimulus(0);
    drain();

    applyStimulus(3);
    drain();
    checkOutput("dup_err", 64'(err), 64'd1);

    doReset();
    checkOutput("err_cleared", 64'(err), 64'd0);
    level_done = 16'h0008;
    tick();
    level_done = '0;
    repeat (5) tick();
    checkOutput("stray_err", 64'(err), 64'd1);
    checkOutput("stray_busy", 64'(busy), 64'd0);
    checkOutput("stray_out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of collection, then a clean sample.
    doReset();
    launch();
    for (int i = 0; i < NL; i++) level_feat[i] = $urandom;
    level_done = 16'h00FF;
    tick();
    level_done = '0;
    doReset();
    checkOutput("rmid_busy", 64'(busy), 64'd0);
    checkOutput("rmid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rmid_mask", 64'(dut.mask), 64'd0);
    applyStimulus(1);
    drain();
    checkOutput("rmid_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hash_feat_collect.md
HASH_FEAT_COLLECT -- requirements
Module: hash_feat_collect

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, width of one interpolated feature word.
REQ-002 SHALL have parameter NUM_LEVEL, default 16, number of hash-grid levels collected per sample.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to launch one sample across all levels.
REQ-006 SHALL have port start_ready, output, 1, high when start is accepted this cycle.
REQ-007 SHALL have port level_en, output, NUM_LEVEL, per-level enable to the interpolation units.
REQ-008 SHALL have port level_done, input, NUM_LEVEL, per-level completion pulse from the interpolation units.
REQ-009 SHALL have port level_feat, input, NUM_LEVEL x DATA_SIZE (unpacked [0:NUM_LEVEL-1]), per-level interpolated feature.
REQ-010 SHALL have port out_valid, output, 1, the collected feature vector is available.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts out_feat.
REQ-012 SHALL have port out_feat, output, NUM_LEVEL x DATA_SIZE (unpacked [0:NUM_LEVEL-1]), the collected vector; index i = level i.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, COLLECT, PUSH.
REQ-016 SHALL drive start_ready = (state==IDLE) && (FIFO count < 2); start is accepted when start && start_ready; on acceptance: IDLE->ISSUE, collect mask cleared to 0.
REQ-017 SHALL assert level_en = all ones for exactly the single ISSUE cycle, all zeros otherwise; ISSUE->COLLECT unconditionally.
REQ-018 SHALL, in COLLECT, for each i with level_done[i]=1 and mask[i]=0, register level_feat[i] into staging slot i and set mask[i]; several levels may complete in the same cycle.
REQ-019 SHALL, in COLLECT, ignore level_done[i] when mask[i]=1 (staging slot unchanged) and set err.
REQ-020 SHALL set err on any level_done bit high while in IDLE, ISSUE or PUSH; the data is discarded.
REQ-021 SHALL transition COLLECT->PUSH on the edge where (mask | level_done) becomes all ones.
REQ-022 SHALL, in PUSH, write all NUM_LEVEL staging slots as one entry into a 2-entry output FIFO, then go PUSH->IDLE.
REQ-023 SHALL make out_valid = (FIFO count != 0) and out_feat = FIFO head, both registered; pop on out_valid && out_ready.
REQ-024 SHALL give latency: last level_done sampled at edge t; PUSH during cycle t..t+1; out_valid high from edge t+2 when the FIFO was empty.
REQ-025 SHALL handle push and pop in the same cycle: count unchanged, head advances, new entry stored behind.
REQ-026 SHALL never overflow the FIFO: the start_ready gating of REQ-016 guarantees space; with count==2, start_ready=0.
REQ-027 SHALL hold out_feat stable while out_valid && !out_ready.
REQ-028 SHALL wrap the FIFO read/write pointers modulo 2.

Reset
REQ-029 SHALL, with rst high at a clock edge, set: state=IDLE, mask=0, FIFO count=0, pointers=0, level_en=0, out_valid=0, busy=0, err=0.
REQ-030 SHALL set the reset value of start_ready to 1 on the first cycle after rst deasserts, and of out_feat to all zeros.
REQ-031 SHALL, when rst is asserted mid-operation, discard the in-flight sample and all FIFO contents; no partial vector is ever emitted.
REQ-032 SHALL clear err only by rst.

Verification
REQ-033 SHALL cover the basic flow: start; all 16 done in one cycle with level_feat[i]=i+1; out_ready=1 -> out_valid 2 cycles later, out_feat[i]=i+1, err=0.
REQ-034 SHALL cover staggered completion: done for level i on cycle 3+i -> single out_valid after level 15; each out_feat[i] equals the value present when its done was sampled.
REQ-035 SHALL cover backpressure: out_ready=0, two samples completed -> count=2, start_ready=0; a third start is not accepted until one pop occurs.
REQ-036 SHALL cover a duplicate done: level 5 done twice with values 0xA then 0xB -> out_feat[5]=0xA, err=1.
REQ-037 SHALL cover a stray done pulse in IDLE -> err=1, no out_valid, FSM stays IDLE.
REQ-038 SHALL cover reset mid-COLLECT with 8 levels done -> after rst: busy=0, out_valid=0, mask=0; a fresh sample then completes normally.
